apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
- REQ-001 Parameter ADDR_WIDTH, default 32: width of the APB address bus and of each requester address.
- REQ-002 Parameter DATA_WIDTH, default 32: width of the APB write and read data buses.
- REQ-003 Parameter TIMEOUT_CYCLES, default 16: ACCESS-cycle limit, used only when APB_ARB_TIMEOUT_EN is defined.
- REQ-004 pclock  in  1  single clock; every flop is on its rising edge.
- REQ-005 presetn  in  1  asynchronous active-low reset.
- REQ-006 req_valid  in  2  per-requester request; bit i belongs to requester i.
- REQ-007 req_write  in  2  per-requester direction: 1 = write, 0 = read.
- REQ-008 req_addr  in  2*ADDR_WIDTH  requester i address in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ-009 req_wdata  in  2*DATA_WIDTH  requester i write data in slice [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-010 req_grant  out  2  one-cycle pulse: requester i's request has been accepted.
- REQ-011 rsp_valid  out  2  one-cycle pulse: requester i's transfer has completed.
- REQ-012 rsp_rdata  out  DATA_WIDTH  read data, qualified by rsp_valid.
- REQ-013 rsp_err  out  1  completion error, qualified by rsp_valid.
- REQ-014 psel, penable, pwrite  out  1 each  APB master controls.
- REQ-015 paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH  APB address and write data.
- REQ-016 prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1  APB slave response.

Function
- REQ-017 FSM states: IDLE, SETUP, ACCESS. No other state is reachable.
- REQ-018 IDLE to SETUP: taken when any req_valid bit is high; the winner's write, address and wdata are latched into paddr, pwrite and pwdata on the same edge.
- REQ-019 Arbitration is round-robin with a 1-bit last-served pointer.
  - Single requester: that requester wins.
  - Both requesting: the requester not served last wins.
  - The pointer updates only on a grant.
- REQ-020 req_grant[i] is a registered pulse, high for exactly the first SETUP cycle.
  - Requester i holds req_valid and its fields until it sees the grant.
  - The block ignores requester i's fields after the grant.
- REQ-021 SETUP: psel=1, penable=0 for exactly one cycle, then the FSM moves to ACCESS.
- REQ-022 ACCESS: psel=1, penable=1.
  - The FSM stays in ACCESS while pready=0 (wait states are unlimited unless REQ-031 applies).
  - On pready=1 the FSM returns to IDLE.
- REQ-023 paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle, and hold their values in IDLE until the next grant.
- REQ-024 On the pready=1 edge, rsp_valid[i] pulses for one cycle, for the winning requester only.
  - rsp_rdata = prdata for a read, 0 for a write.
  - rsp_err = pslverr.
- REQ-025 In the rsp_valid cycle the FSM is in IDLE with psel=0. Minimum transfer is 3 cycles: IDLE, SETUP, ACCESS. There is no direct ACCESS-to-SETUP transition.
- REQ-026 At most one bit of req_grant and of rsp_valid is ever high. Each grant produces exactly one rsp_valid.
- REQ-027 rsp_rdata and rsp_err hold their last values between pulses.

Reset
- REQ-028 On presetn=0, immediately and regardless of clock, all of the following are forced to 0: psel, penable, pwrite, paddr, pwdata, req_grant, rsp_valid, rsp_rdata, rsp_err. The FSM goes to IDLE and the pointer to 0 (requester 0 wins the first tie).
- REQ-029 A reset asserted mid-transfer abandons the transfer with no rsp_valid. After deassertion the first arbitration occurs on the first rising edge with presetn=1.

Configuration
- REQ-030 The macro APB_ARB_TIMEOUT_EN selects the ACCESS timeout feature.
- REQ-031 With APB_ARB_TIMEOUT_EN defined:
  - An ACCESS-cycle counter runs, cleared on entry to SETUP.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the FSM returns to IDLE (psel=0, penable=0).
  - rsp_valid[i] then pulses with rsp_err=1 and rsp_rdata=0.
- REQ-032 Without APB_ARB_TIMEOUT_EN: no counter is synthesised, and ACCESS waits indefinitely for pready.

Verification
- REQ-033 Single read: req_valid=01, addr0=0x0000_0010, slave pready=1 in first ACCESS with prdata=0xDEAD_BEEF -> grant=01 in SETUP; psel 2 cycles; penable 1 cycle; rsp_valid=01, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- REQ-034 Simultaneous: req_valid=11 held after reset (addr0=0x100, addr1=0x200 writes) -> requester 0 served first, then 1; next tie goes to 0; paddr sequence 0x100, 0x200.
- REQ-035 Wait states: pready low for 3 ACCESS cycles, pslverr=1 at completion -> penable high 4 cycles, paddr/pwdata stable, rsp_err=1, one rsp_valid pulse.
- REQ-036 Reset mid-ACCESS: presetn low during ACCESS -> psel/penable 0 asynchronously, no rsp_valid; after release a pending req1 is granted normally.
- REQ-037 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_rdata=0; without macro psel remains high after 100 cycles.

Source files
------------

// File: rtl/apb_arb_master.sv
//==============================================================================
// Module      : apb_arb_master
// Description : Two-requester round-robin arbiter driving a single APB master
//               port. Optional ACCESS timeout enabled by APB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_arb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclock,
  input  logic                    presetn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_grant,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_prio;     // requester that wins the next tie (inverse of last served)
  logic   r_owner;    // requester owning the transfer in flight
  logic   w_winner;
  logic   w_grant;
  logic   w_done;
  logic   w_timeout;

  assign w_winner = (req_valid == 2'b11) ? r_prio : req_valid[1];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= '0;
    end else if (r_state == S_ACCESS) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Fires in the last permitted ACCESS cycle when the slave is still stalling.
  assign w_timeout = (r_state == S_ACCESS) && !pready &&
                     (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_done  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_next  = S_SETUP;
          w_grant = 1'b1;
        end
      end
      S_SETUP: begin
        psel   = 1'b1;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || w_timeout) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      req_grant <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
    end else begin
      req_grant <= 2'b00;
      rsp_valid <= 2'b00;
      if (w_grant) begin
        paddr     <= w_winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        pwdata    <= w_winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        pwrite    <= req_write[w_winner];
        req_grant <= w_winner ? 2'b10 : 2'b01;
        r_owner   <= w_winner;
        r_prio    <= ~w_winner;
      end
      // A timeout completes with pready low, which forces an error with zero data.
      if (w_done) begin
        rsp_valid <= r_owner ? 2'b10 : 2'b01;
        rsp_rdata <= (pwrite || !pready) ? '0 : prdata;
        rsp_err   <= pslverr || !pready;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_arb_master.sv
//==============================================================================
// Module      : tb_apb_arb_master
// Description : Scoreboard bench for apb_arb_master (APB_ARB_TIMEOUT_EN aware).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb_arb_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclock = 1'b0;
  logic          presetn;
  logic [1:0]    req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_grant, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 pclock = ~pclock;

  apb_arb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .pclock(pclock), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic tick();
    @(posedge pclock);
    #1;
  endtask

  task automatic apply_reset();
    presetn = 1'b0;
    pready  = 1'b0;
    tick();
    tick();
    presetn = 1'b1;
  endtask

  // Runs one transfer as requester + slave; leaves the bench in the rsp_valid cycle.
  task automatic run_xfer(input int waits, input logic [DW-1:0] rdat, input logic err,
                          input int budget, output int n_sel, output int n_en,
                          output logic [1:0] gnt, output int gnt_cyc, output logic stable,
                          output logic found, output logic [AW-1:0] a_seen,
                          output logic [DW-1:0] d_seen, output logic w_seen);
    logic have;
    n_sel = 0; n_en = 0; gnt = 2'b00; gnt_cyc = -1; stable = 1'b1; found = 1'b0;
    have = 1'b0; a_seen = '0; d_seen = '0; w_seen = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    for (int c = 0; c < budget && !found; c++) begin
      tick();
      if (rsp_valid != 2'b00) found = 1'b1;
      if (req_grant != 2'b00) begin
        gnt = req_grant;
        gnt_cyc = c;
        req_valid = req_valid & ~req_grant;
      end
      if (psel) begin
        n_sel++;
        if (!have) begin
          a_seen = paddr; d_seen = pwdata; w_seen = pwrite; have = 1'b1;
        end else if (paddr !== a_seen || pwdata !== d_seen || pwrite !== w_seen) begin
          stable = 1'b0;
        end
      end
      if (penable) begin
        n_en++;
        if (n_en - 1 == waits) begin
          pready = 1'b1; prdata = rdat; pslverr = err;
        end else begin
          pready = 1'b0; prdata = ~rdat; pslverr = ~err;
        end
      end else begin
        pready = 1'b0; prdata = 32'h5A5A_5A5A; pslverr = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [AW+2*DW+8:0] outs;
    presetn = 1'b1;
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {32'h200, 32'h100}; req_wdata = {32'hB, 32'hA};
    prdata = 32'hFFFF_FFFF; pready = 1'b1; pslverr = 1'b1;
    #1 presetn = 1'b0;
    #1;
    outs = {psel, penable, pwrite, paddr, pwdata, req_grant, rsp_valid, rsp_rdata, rsp_err};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    req_valid = 2'b00; pready = 1'b0; pslverr = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({psel, req_grant, rsp_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_hold: psel=%b grant=%b rsp=%b, want 0", psel, req_grant, rsp_valid);
    end
    presetn = 1'b1;
  endtask

  task automatic test_single_read();
    int n_sel, n_en, gc; logic [1:0] g; logic st, fnd, w; logic [AW-1:0] a; logic [DW-1:0] d;
    exp_t e;
    req_valid = 2'b01; req_write = 2'b00;
    req_addr = {32'h0000_0999, 32'h0000_0010}; req_wdata = '0;
    exp_q.push_back('{id: 2'b01, rdata: 32'hDEAD_BEEF, err: 1'b0});
    run_xfer(0, 32'hDEAD_BEEF, 1'b0, 10, n_sel, n_en, g, gc, st, fnd, a, d, w);
    n_cmp++;
    if (g !== 2'b01 || gc !== 0) begin
      n_err++; $display("FAIL single_grant: got %b@%0d, want 01@0", g, gc);
    end
    n_cmp++;
    if (n_sel !== 2 || n_en !== 1) begin
      n_err++; $display("FAIL single_phases: psel=%0d penable=%0d cycles, want 2/1", n_sel, n_en);
    end
    n_cmp++;
    if (a !== 32'h10 || w !== 1'b0) begin
      n_err++; $display("FAIL single_addr: got %h w=%b, want 00000010 w=0", a, w);
    end
    n_cmp++;
    if (!fnd || exp_q.size() == 0) begin
      n_err++; $display("FAIL single_rsp: no response (found=%b)", fnd);
    end else begin
      e = exp_q.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err} !== {e.id, e.rdata, e.err}) begin
        n_err++;
        $display("FAIL single_rsp: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                 rsp_valid, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
      end
    end
    n_cmp++;
    if (psel !== 1'b0 || paddr !== 32'h10) begin
      n_err++; $display("FAIL single_idle: psel=%b paddr=%h, want 0/00000010", psel, paddr);
    end
  endtask

  task automatic test_round_robin();
    int n_sel, n_en, gc; logic [1:0] g; logic st, fnd, w; logic [AW-1:0] a; logic [DW-1:0] d;
    exp_t e;
    logic [1:0]    want_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [AW-1:0] want_a [4] = '{32'h100, 32'h200, 32'h104, 32'h204};
    apply_reset();
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {32'h200, 32'h100}; req_wdata = {32'hB0B0_0002, 32'hA0A0_0001};
    exp_q.push_back('{id: 2'b01, rdata: '0, err: 1'b0});
    exp_q.push_back('{id: 2'b10, rdata: '0, err: 1'b0});
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        req_valid = 2'b11; req_write = 2'b00;
        req_addr = {32'h204, 32'h104};
        exp_q.push_back('{id: 2'b01, rdata: 32'h1234_5678, err: 1'b0});
        exp_q.push_back('{id: 2'b10, rdata: 32'h1234_5678, err: 1'b0});
      end
      run_xfer(0, (k < 2) ? 32'hFFFF_FFFF : 32'h1234_5678, 1'b0, 10,
               n_sel, n_en, g, gc, st, fnd, a, d, w);
      n_cmp++;
      if (g !== want_g[k] || a !== want_a[k]) begin
        n_err++;
        $display("FAIL rr_order[%0d]: grant=%b addr=%h, want %b/%h", k, g, a, want_g[k], want_a[k]);
      end
      n_cmp++;
      if (!fnd || exp_q.size() == 0) begin
        n_err++; $display("FAIL rr_rsp[%0d]: no response", k);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_valid, rsp_rdata, rsp_err} !== {e.id, e.rdata, e.err}) begin
          n_err++;
          $display("FAIL rr_rsp[%0d]: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   k, rsp_valid, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
        end
      end
      if (k == 0) begin
        n_cmp++;
        if (d !== 32'hA0A0_0001 || w !== 1'b1) begin
          n_err++; $display("FAIL rr_wdata: got %h w=%b, want a0a00001 w=1", d, w);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int n_sel, n_en, gc; logic [1:0] g; logic st, fnd, w; logic [AW-1:0] a; logic [DW-1:0] d;
    exp_t e;
    req_valid = 2'b10; req_write = 2'b00;
    req_addr = {32'h0000_003C, 32'h0}; req_wdata = {32'h0000_55AA, 32'h0};
    exp_q.push_back('{id: 2'b10, rdata: 32'hCAFE_F00D, err: 1'b1});
    run_xfer(3, 32'hCAFE_F00D, 1'b1, 20, n_sel, n_en, g, gc, st, fnd, a, d, w);
    n_cmp++;
    if (n_en !== 4 || n_sel !== 5) begin
      n_err++; $display("FAIL wait_phases: penable=%0d psel=%0d, want 4/5", n_en, n_sel);
    end
    n_cmp++;
    if (st !== 1'b1 || a !== 32'h3C || d !== 32'h55AA) begin
      n_err++; $display("FAIL wait_stable: stable=%b addr=%h wdata=%h, want 1/3c/55aa", st, a, d);
    end
    n_cmp++;
    if (!fnd || exp_q.size() == 0) begin
      n_err++; $display("FAIL wait_rsp: no response");
    end else begin
      e = exp_q.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err} !== {e.id, e.rdata, e.err}) begin
        n_err++;
        $display("FAIL wait_rsp: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                 rsp_valid, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
      end
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b1) begin
      n_err++;
      $display("FAIL rsp_hold: v=%b d=%h e=%b, want 00/cafef00d/1", rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_reset_mid_access();
    int n_sel, n_en, gc; logic [1:0] g; logic st, fnd, w, seen_rsp; logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_t e;
    req_valid = 2'b01; req_write = 2'b00;
    req_addr = {32'h80, 32'h40}; pready = 1'b0;
    tick();
    if (req_grant[0]) req_valid[0] = 1'b0;
    tick();
    n_cmp++;
    if (penable !== 1'b1) begin
      n_err++; $display("FAIL mid_access_entry: penable=%b, want 1", penable);
    end
    req_valid[1] = 1'b1;
    #2 presetn = 1'b0;
    #1;
    n_cmp++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 2'b00) begin
      n_err++; $display("FAIL async_abort: psel=%b penable=%b rsp=%b, want 0", psel, penable, rsp_valid);
    end
    seen_rsp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (rsp_valid !== 2'b00 || psel !== 1'b0) seen_rsp = 1'b1;
    end
    n_cmp++;
    if (seen_rsp) begin
      n_err++; $display("FAIL abort_no_rsp: activity seen during reset, want none");
    end
    presetn = 1'b1;
    exp_q.push_back('{id: 2'b10, rdata: 32'h0BAD_F00D, err: 1'b0});
    run_xfer(0, 32'h0BAD_F00D, 1'b0, 10, n_sel, n_en, g, gc, st, fnd, a, d, w);
    n_cmp++;
    if (g !== 2'b10 || gc !== 0 || a !== 32'h80) begin
      n_err++; $display("FAIL post_reset_grant: grant=%b@%0d addr=%h, want 10@0/80", g, gc, a);
    end
    n_cmp++;
    if (!fnd || exp_q.size() == 0) begin
      n_err++; $display("FAIL post_reset_rsp: no response");
    end else begin
      e = exp_q.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err} !== {e.id, e.rdata, e.err}) begin
        n_err++;
        $display("FAIL post_reset_rsp: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                 rsp_valid, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_timeout();
    int n_sel, n_en, gc; logic [1:0] g; logic st, fnd, w; logic [AW-1:0] a; logic [DW-1:0] d;
`ifdef APB_ARB_TIMEOUT_EN
    exp_t e;
`endif
    req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h44};
`ifdef APB_ARB_TIMEOUT_EN
    exp_q.push_back('{id: 2'b01, rdata: '0, err: 1'b1});
    run_xfer(1000, 32'h1111_1111, 1'b0, 40, n_sel, n_en, g, gc, st, fnd, a, d, w);
    n_cmp++;
    if (n_en !== 16 || psel !== 1'b0) begin
      n_err++; $display("FAIL timeout_len: penable=%0d psel=%b, want 16/0", n_en, psel);
    end
    n_cmp++;
    if (!fnd || exp_q.size() == 0) begin
      n_err++; $display("FAIL timeout_rsp: no response");
    end else begin
      e = exp_q.pop_front();
      if ({rsp_valid, rsp_rdata, rsp_err} !== {e.id, e.rdata, e.err}) begin
        n_err++;
        $display("FAIL timeout_rsp: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                 rsp_valid, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
      end
    end
`else
    run_xfer(1000, 32'h1111_1111, 1'b0, 105, n_sel, n_en, g, gc, st, fnd, a, d, w);
    n_cmp++;
    if (fnd !== 1'b0 || psel !== 1'b1 || penable !== 1'b1 || n_en < 100) begin
      n_err++;
      $display("FAIL no_timeout: rsp=%b psel=%b penable=%b access=%0d, want 0/1/1/>=100",
               fnd, psel, penable, n_en);
    end
    apply_reset();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_reset_mid_access();
    test_timeout();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
